// File: rtl/chess_pkg.sv
// Shared definitions for the chess clock turn controller: FSM state codes and loser flags.
package chess_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN_P1  = 3'd1,
      RUN_P2  = 3'd2,
      PAUSE   = 3'd3,
      TIMEOUT = 3'd4
   } state_t;

   localparam logic [1:0] LOSER_NONE = 2'b00;
   localparam logic [1:0] LOSER_P1   = 2'b01;
   localparam logic [1:0] LOSER_P2   = 2'b10;

endpackage

// File: rtl/chess_turn_controller_btn_sync.sv
// Raw button conditioning: 2-FF synchronizer, stability debounce, and a one-cycle press pulse
// on each accepted low-to-high transition.
module btn_sync #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic CLK,
   input  logic CLR_N,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter only runs while the synced level disagrees with the accepted one,
   // so any bounce back to the old level restarts the stability window.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/chess_turn_controller.sv
// Chess clock turn controller: button conditioning, game FSM, and 1 Hz tick routing to the
// active player's counter chain.
module chess_turn_controller
   import chess_pkg::*;
#(
   parameter int unsigned CLK_DIV         = 100_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       BTN_P1,
   input  logic       BTN_P2,
   input  logic       BTN_START,
   input  logic       BTN_PAUSE,
   input  logic       TIMEOUT_P1,
   input  logic       TIMEOUT_P2,
   output logic       IMPULSE_P1,
   output logic       IMPULSE_P2,
   output logic       CE_P1,
   output logic       CE_P2,
   output logic       LOAD,
   output logic [2:0] STATE,
   output logic [1:0] LOSER
);

   localparam int unsigned PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

   logic p1_press, p2_press, start_press, pause_press;

   btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_p1 (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .btn_i   (BTN_P1),
      .press_o (p1_press)
   );

   btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_p2 (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .btn_i   (BTN_P2),
      .press_o (p2_press)
   );

   btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_start (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .btn_i   (BTN_START),
      .press_o (start_press)
   );

   btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_pause (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .btn_i   (BTN_PAUSE),
      .press_o (pause_press)
   );

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          saved_p2_q, saved_p2_d;
   logic [1:0]    loser_q, loser_d;
   logic          load_q, load_d;
   logic          imp_p1_q, imp_p1_d;
   logic          imp_p2_q, imp_p2_d;
   logic          ce_p1_q, ce_p2_q;

   // Ticks only fire when the running state persists; leaving RUN in the
   // same cycle suppresses the impulse and holds the prescaler.
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      saved_p2_d = saved_p2_q;
      loser_d    = loser_q;
      load_d     = 1'b0;
      imp_p1_d   = 1'b0;
      imp_p2_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_press) begin
               state_d = RUN_P1;
               presc_d = '0;
            end
         end
         RUN_P1: begin
            if (TIMEOUT_P1) begin
               state_d = TIMEOUT;
               loser_d = LOSER_P1;
            end else if (pause_press) begin
               state_d    = PAUSE;
               saved_p2_d = 1'b0;
            end else if (p1_press) begin
               state_d = RUN_P2;
               presc_d = '0;
            end else if (presc_q == PRESC_MAX) begin
               presc_d  = '0;
               imp_p1_d = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         RUN_P2: begin
            if (TIMEOUT_P2) begin
               state_d = TIMEOUT;
               loser_d = LOSER_P2;
            end else if (pause_press) begin
               state_d    = PAUSE;
               saved_p2_d = 1'b1;
            end else if (p2_press) begin
               state_d = RUN_P1;
               presc_d = '0;
            end else if (presc_q == PRESC_MAX) begin
               presc_d  = '0;
               imp_p2_d = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         PAUSE: begin
            if (pause_press) begin
               state_d = saved_p2_q ? RUN_P2 : RUN_P1;
            end
         end
         TIMEOUT: begin
            if (start_press) begin
               state_d = IDLE;
               load_d  = 1'b1;
               loser_d = LOSER_NONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         saved_p2_q <= 1'b0;
         loser_q    <= LOSER_NONE;
         load_q     <= 1'b0;
         imp_p1_q   <= 1'b0;
         imp_p2_q   <= 1'b0;
         ce_p1_q    <= 1'b0;
         ce_p2_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         saved_p2_q <= saved_p2_d;
         loser_q    <= loser_d;
         load_q     <= load_d;
         imp_p1_q   <= imp_p1_d;
         imp_p2_q   <= imp_p2_d;
         ce_p1_q    <= (state_d == RUN_P1);
         ce_p2_q    <= (state_d == RUN_P2);
      end
   end

   assign IMPULSE_P1 = imp_p1_q;
   assign IMPULSE_P2 = imp_p2_q;
   assign CE_P1      = ce_p1_q;
   assign CE_P2      = ce_p2_q;
   assign LOAD       = load_q;
   assign STATE      = state_q;
   assign LOSER      = loser_q;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Scoreboard bench: a game-rule reference model predicts every output change; a monitor
// compares each observed DUT output change against the predicted one.
module tb_chess_turn_controller;

   localparam int CLK_DIV = 4;
   localparam int DEB     = 2;

   logic       CLK = 1'b0;
   logic       CLR_N = 1'b0;
   logic       BTN_P1 = 1'b0, BTN_P2 = 1'b0, BTN_START = 1'b0, BTN_PAUSE = 1'b0;
   logic       TIMEOUT_P1 = 1'b0, TIMEOUT_P2 = 1'b0;
   logic       IMPULSE_P1, IMPULSE_P2, CE_P1, CE_P2, LOAD;
   logic [2:0] STATE;
   logic [1:0] LOSER;

   int checks = 0;
   int failures = 0;

   chess_turn_controller #(
      .CLK_DIV         (CLK_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .CLK        (CLK),
      .CLR_N      (CLR_N),
      .BTN_P1     (BTN_P1),
      .BTN_P2     (BTN_P2),
      .BTN_START  (BTN_START),
      .BTN_PAUSE  (BTN_PAUSE),
      .TIMEOUT_P1 (TIMEOUT_P1),
      .TIMEOUT_P2 (TIMEOUT_P2),
      .IMPULSE_P1 (IMPULSE_P1),
      .IMPULSE_P2 (IMPULSE_P2),
      .CE_P1      (CE_P1),
      .CE_P2      (CE_P2),
      .LOAD       (LOAD),
      .STATE      (STATE),
      .LOSER      (LOSER)
   );

   // Posedges at 5, 15, 25 ...; negedges at 10, 20, 30 ...
   always #5 CLK = ~CLK;

   typedef struct {
      longint     t;
      logic [9:0] v;
   } ev_t;

   ev_t exp_q[$];

   // Reference model: game phase 0..4, saved player 1/2, loser player number.
   int         m_state = 0, m_saved = 1, m_loser = 0, m_elapsed = 0;
   logic       m_imp1 = 1'b0, m_imp2 = 1'b0, m_load = 1'b0;
   logic [7:0] sh [4];
   logic       lvl [4];
   logic       prs [4];
   logic [9:0] m_last = '0;

   function automatic logic [9:0] dut_vec();
      return {STATE, CE_P1, CE_P2, IMPULSE_P1, IMPULSE_P2, LOAD, LOSER};
   endfunction

   function automatic logic [9:0] model_vec();
      return {3'(m_state), m_state == 1, m_state == 2, m_imp1, m_imp2, m_load, 2'(m_loser)};
   endfunction

   task automatic push_if_changed(input longint t);
      logic [9:0] v;
      v = model_vec();
      if (v != m_last) begin
         exp_q.push_back('{t: t, v: v});
         m_last = v;
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_saved = 1;
      m_loser = 0;
      m_elapsed = 0;
      m_imp1 = 1'b0;
      m_imp2 = 1'b0;
      m_load = 1'b0;
      for (int b = 0; b < 4; b++) begin
         sh[b] = '0;
         lvl[b] = 1'b0;
         prs[b] = 1'b0;
      end
   endtask

   initial begin
      int   me;
      logic to_hit, all_diff;
      logic raw [4];
      model_reset();
      forever begin
         @(posedge CLK or negedge CLR_N);
         if (!CLR_N) begin
            model_reset();
            push_if_changed(((longint'($time) + 9) / 10) * 10);
         end else begin
            raw[0] = BTN_START;
            raw[1] = BTN_PAUSE;
            raw[2] = BTN_P1;
            raw[3] = BTN_P2;
            m_imp1 = 1'b0;
            m_imp2 = 1'b0;
            m_load = 1'b0;
            // Game rules, acting on presses recognised at the previous edge.
            case (m_state)
               0: if (prs[0]) begin
                  m_state = 1;
                  m_elapsed = 0;
               end
               1, 2: begin
                  me = m_state;
                  to_hit = (me == 1) ? TIMEOUT_P1 : TIMEOUT_P2;
                  if (to_hit) begin
                     m_state = 4;
                     m_loser = me;
                  end else if (prs[1]) begin
                     m_saved = me;
                     m_state = 3;
                  end else if (prs[me + 1]) begin
                     m_state = 3 - me;
                     m_elapsed = 0;
                  end else begin
                     m_elapsed++;
                     if (m_elapsed == CLK_DIV) begin
                        m_elapsed = 0;
                        if (me == 1) m_imp1 = 1'b1;
                        else m_imp2 = 1'b1;
                     end
                  end
               end
               3: if (prs[1]) m_state = m_saved;
               4: if (prs[0]) begin
                  m_state = 0;
                  m_load = 1'b1;
                  m_loser = 0;
               end
               default: m_state = 0;
            endcase
            // A press is recognised once the synced level (raw delayed two edges)
            // has shown the new value for DEB consecutive samples.
            for (int b = 0; b < 4; b++) begin
               sh[b] = {sh[b][6:0], raw[b]};
               all_diff = 1'b1;
               for (int k = 2; k <= DEB + 1; k++) begin
                  if (sh[b][k] == lvl[b]) all_diff = 1'b0;
               end
               prs[b] = 1'b0;
               if (all_diff) begin
                  lvl[b] = ~lvl[b];
                  prs[b] = lvl[b];
               end
            end
            push_if_changed(longint'($time) + 5);
         end
      end
   end

   // Monitor: every change of the DUT output vector must match the next predicted event.
   initial begin
      logic [9:0] last, cur;
      ev_t        e;
      last = '0;
      forever begin
         @(negedge CLK);
         cur = dut_vec();
         if (cur !== last) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change t=%0t got=%b required=no change", $time, cur);
            end else begin
               e = exp_q.pop_front();
               if (e.t != longint'($time) || e.v !== cur) begin
                  failures++;
                  $display("FAIL output_event got=%b at t=%0t required=%b at t=%0d",
                           cur, $time, e.v, e.t);
               end
            end
            last = cur;
         end
      end
   end

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: BTN_START = v;
         1: BTN_PAUSE = v;
         2: BTN_P1 = v;
         3: BTN_P2 = v;
         4: TIMEOUT_P1 = v;
         default: TIMEOUT_P2 = v;
      endcase
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press(input int b, input int hold, input int gap);
      set_btn(b, 1'b1);
      wait_cycles(hold);
      set_btn(b, 1'b0);
      wait_cycles(gap);
   endtask

   initial begin
      wait_cycles(3);
      checks++;
      if (dut_vec() !== 10'b0) begin
         failures++;
         $display("FAIL reset_state got=%b required=%b", dut_vec(), 10'b0);
      end
      CLR_N = 1'b1;
      wait_cycles(2);

      // Start, then let player 1 run for a few ticks.
      press(0, 6, 12 + $urandom_range(0, 3));
      // Switch to player 2.
      press(2, 4, 3 + $urandom_range(0, 4));
      // Pause, idle long, resume.
      press(1, 4, 20);
      press(1, 4, 10 + $urandom_range(0, 3));
      // Back to player 1, then timeout coincident with a player 1 press.
      press(3, 4, 6);
      BTN_P1 = 1'b1;
      wait_cycles(4);
      TIMEOUT_P1 = 1'b1;
      wait_cycles(3);
      BTN_P1 = 1'b0;
      TIMEOUT_P1 = 1'b0;
      wait_cycles(3);
      // Re-arm with LOAD, then restart.
      press(0, 5, 4);
      press(0, 5, 4);
      // Stale timeout on the idle player and a bouncing player 1 button.
      TIMEOUT_P2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         BTN_P1 = ~BTN_P1;
         wait_cycles(1);
      end
      BTN_P1 = 1'b0;
      wait_cycles(8);
      TIMEOUT_P2 = 1'b0;
      // Switch to player 2, then asynchronous reset mid-cycle.
      press(2, 4, 3);
      @(posedge CLK);
      #2 CLR_N = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 10'b0) begin
         failures++;
         $display("FAIL async_reset got=%b required=%b", dut_vec(), 10'b0);
      end
      wait_cycles(2);
      CLR_N = 1'b1;
      wait_cycles(2);

      // Randomized play.
      for (int i = 0; i < 400; i++) begin
         int b;
         b = $urandom_range(0, 5);
         if (b >= 4) set_btn(b, $urandom_range(0, 3) == 0);
         else set_btn(b, 1'($urandom_range(0, 1)));
         wait_cycles($urandom_range(1, 6));
      end
      for (int b = 0; b < 6; b++) set_btn(b, 1'b0);
      wait_cycles(20);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_events got=0 changes required=%0d pending changes", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
